id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute stage of the RV32I pipeline. It drives rs1/rs2 read addresses to the register file, captures the returned operands with write-back bypass, and generates the sign-extended immediate. Each cycle it registers the decoded instruction into the ID/EX pipeline register. It also detects load-use hazards, stalling fetch/decode and inserting a bubble into EX, and honours branch flushes from EX.

## Interface
- XLEN, 32, datapath width (fixed at 32 for RV32I)
- Clk  input  1  clock, all state updates on rising edge
- Rst  input  1  reset, synchronous, active-low
- if_id_valid  input  1  IF/ID register holds a valid instruction
- if_id_pc  input  32  PC of instruction in decode
- if_id_instr  input  32  instruction word in decode
- rf_read1  output  5  rs1 address to register file (instr[19:15])
- rf_read2  output  5  rs2 address to register file (instr[24:20])
- rf_data1  input  32  register file read data, port 1
- rf_data2  input  32  register file read data, port 2
- wb_wen  input  1  write-back stage writing this cycle
- wb_rd  input  5  write-back destination
- wb_data  input  32  write-back data
- ex_flush  input  1  branch/jump taken in EX; kill decode contents
- stall_out  output  1  hold PC and IF/ID (load-use)
- ex_valid  output  1  ID/EX holds a valid instruction
- ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  output  32 each  registered PC, operands, immediate
- ex_rs1, ex_rs2, ex_rd  output  5 each  registered register numbers, for forwarding
- ex_opcode  output  7; ex_funct3  output  3; ex_funct7b5  output  1 (instr[30])
- ex_is_load  output  1  opcode 0000011
- ex_reg_wen  output  1  instruction writes rd, with rd != 0

## Operation
- Operand select, combinational, per source: if rs == 0, value is 0; else if wb_wen && wb_rd == rs, value is wb_data; else value is rf_data.
- rs1 is used by all opcodes except LUI (0110111), AUIPC (0010111) and JAL (1101111).
- rs2 is used only by R (0110011), S (0100011) and B (1100011).
- Immediate forms, all sign-extended from instr[31]:
  - I: loads, OP-IMM, JALR.
  - S: stores.
  - B: branches, bit0 = 0.
  - U: LUI/AUIPC, low 12 bits = 0.
  - J: JAL, bit0 = 0.
  - All other opcodes: imm = 0.
- reg_wen is set for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP, and only when rd != 0.
- Hazard definition: `hazard = if_id_valid && ex_valid && ex_is_load && ex_rd != 0 && ((rs1_used && ex_rd == rs1) || (rs2_used && ex_rd == rs2))`.
- stall_out = hazard && !ex_flush. The value is combinational, within the same cycle.
- State machine:
  - RUN: normal operation.
  - BUBBLE: the load-use bubble has just been inserted.
  - RUN to BUBBLE: on a stall.
  - BUBBLE to RUN: always, after exactly one cycle.
  - A second stall is impossible in BUBBLE, because ex_valid = 0 there.
- ID/EX update, evaluated in priority order on each rising edge:
  1. !Rst: all outputs are cleared and the state becomes RUN.
  2. ex_flush: ex_valid <= 0 and the other fields are don't-care.
  3. stall_out: ex_valid <= 0 (bubble) and ex_reg_wen <= 0, ex_is_load <= 0.
  4. Otherwise: all fields are loaded from decode, and ex_valid <= if_id_valid.
- When ex_valid = 0, ex_reg_wen and ex_is_load must also be 0.

## Timing
- Reset value: every output 0, including ex_valid, ex_imm and stall_out; state RUN.
- Reset mid-stall: the bubble is dropped and the block returns to RUN.
- Latency: a decoded instruction appears on the ex_* outputs 1 cycle after it is present in IF/ID.
- rf_read1/rf_read2 follow if_id_instr combinationally. This holds even while if_id_valid = 0.
- A load-use hazard costs exactly 1 stall cycle:
  - Cycle N: stall_out = 1.
  - Cycle N+1: ex_valid = 0, stall_out = 0; the dependent instruction is still in IF/ID.
  - Cycle N+2: the dependent instruction is in ID/EX.
- Simultaneous ex_flush and hazard: the flush wins, stall_out = 0 and there is no BUBBLE state.
- Simultaneous wb write and read of the same register: the WB value is used, with no extra cycle.
- A wb write to x0 is never bypassed.

## Test plan
- Reset: hold Rst = 0 for 2 cycles with if_id_valid = 1 -> all ex_* = 0 and stall_out = 0; the first valid instruction appears 1 cycle after Rst = 1.
- Immediates:
  - `addi x1,x0,-1` (0xFFF00093) -> ex_imm = 0xFFFFFFFF, ex_rd = 1, ex_reg_wen = 1.
  - `lui x2,0x12345` -> ex_imm = 0x12345000.
  - `beq` with offset -4 -> ex_imm = 0xFFFFFFFC.
- WB bypass: rf_data1 = 0x11; wb_wen = 1, wb_rd = 5, wb_data = 0xAA; decode `add x3,x5,x0` -> ex_rs1_val = 0xAA, ex_rs2_val = 0. Repeat with wb_rd = 0 -> no bypass for x0.
- Load-use:
  - `lw x6,0(x1)` in EX, `add x7,x6,x2` in decode -> stall_out = 1 for 1 cycle, ex_valid = 0 next, then the add arrives with ex_rs1 = 6.
  - `lui x8,...` after the lw -> no stall.
- Flush priority: same load-use pair with ex_flush = 1 -> stall_out = 0, ex_valid = 0 next cycle, no BUBBLE; the next instruction passes normally.
- Store/x0 cases:
  - `lw x0` followed by `add x1,x0,x0` -> no stall.
  - `sw x6,0(x1)` after `lw x6` -> stall, because rs2 is used.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I decode-to-execute stage.
// Drives register file read addresses, selects operands with write-back bypass,
// builds the sign-extended immediate, detects load-use hazards and registers
// the decoded instruction into the ID/EX pipeline register.
// Ports:
//   Clk, Rst                        clock, synchronous active-low reset
//   if_id_valid/pc/instr            instruction currently in decode
//   rf_read1/2 -> rf_data1/2        register file read addresses / data
//   wb_wen, wb_rd, wb_data          write-back port used for bypass
//   ex_flush                        taken branch/jump in EX, kills decode
//   stall_out                       combinational load-use stall to IF/ID
//   ex_*                            registered ID/EX pipeline fields
module id_ex_stage (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        if_id_valid,
    input  logic [31:0] if_id_pc,
    input  logic [31:0] if_id_instr,
    output logic [4:0]  rf_read1,
    output logic [4:0]  rf_read2,
    input  logic [31:0] rf_data1,
    input  logic [31:0] rf_data2,
    input  logic        wb_wen,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        ex_flush,
    output logic        stall_out,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs1_val,
    output logic [31:0] ex_rs2_val,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic [6:0]  ex_opcode,
    output logic [2:0]  ex_funct3,
    output logic        ex_funct7b5,
    output logic        ex_is_load,
    output logic        ex_reg_wen
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic {RUN, BUBBLE} state_t;
    state_t state;

    logic [6:0]       opcode;
    logic [REG_W-1:0] rs1, rs2, rd;
    logic [XLEN-1:0]  imm, rs1_val, rs2_val;
    logic             rs1_used, rs2_used, reg_wen_d, is_load_d, hazard;

    // Field extraction, immediate generation and per-opcode control decode
    always_comb begin
        opcode    = if_id_instr[6:0];
        rd        = if_id_instr[11:7];
        rs1       = if_id_instr[19:15];
        rs2       = if_id_instr[24:20];
        imm       = '0;
        rs1_used  = 1'b1;
        rs2_used  = 1'b0;
        reg_wen_d = 1'b0;
        is_load_d = 1'b0;
        case (opcode)
            OP_LOAD: begin
                imm       = {{20{if_id_instr[31]}}, if_id_instr[31:20]};
                reg_wen_d = 1'b1;
                is_load_d = 1'b1;
            end
            OP_IMM, OP_JALR: begin
                imm       = {{20{if_id_instr[31]}}, if_id_instr[31:20]};
                reg_wen_d = 1'b1;
            end
            OP_STORE: begin
                imm      = {{20{if_id_instr[31]}}, if_id_instr[31:25], if_id_instr[11:7]};
                rs2_used = 1'b1;
            end
            OP_BRANCH: begin
                imm      = {{19{if_id_instr[31]}}, if_id_instr[31], if_id_instr[7],
                            if_id_instr[30:25], if_id_instr[11:8], 1'b0};
                rs2_used = 1'b1;
            end
            OP_REG: begin
                rs2_used  = 1'b1;
                reg_wen_d = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                imm       = {if_id_instr[31:12], 12'b0};
                rs1_used  = 1'b0;
                reg_wen_d = 1'b1;
            end
            OP_JAL: begin
                imm       = {{11{if_id_instr[31]}}, if_id_instr[31], if_id_instr[19:12],
                             if_id_instr[20], if_id_instr[30:21], 1'b0};
                rs1_used  = 1'b0;
                reg_wen_d = 1'b1;
            end
            default: ;
        endcase
        // x0 is never written, so it never counts as a destination
        if (rd == '0)
            reg_wen_d = 1'b0;
    end

    // Operand select: x0 reads zero, a same-cycle write-back wins over the RF
    always_comb begin
        if (rs1 == '0)
            rs1_val = '0;
        else if (wb_wen && (wb_rd == rs1))
            rs1_val = wb_data;
        else
            rs1_val = rf_data1;

        if (rs2 == '0)
            rs2_val = '0;
        else if (wb_wen && (wb_rd == rs2))
            rs2_val = wb_data;
        else
            rs2_val = rf_data2;
    end

    assign rf_read1 = rs1;
    assign rf_read2 = rs2;

    // Load in EX whose destination is a source of the instruction in decode
    assign hazard = if_id_valid && ex_valid && ex_is_load && (ex_rd != '0) &&
                    ((rs1_used && (ex_rd == rs1)) || (rs2_used && (ex_rd == rs2)));
    assign stall_out = hazard && !ex_flush;

    // ID/EX register and RUN/BUBBLE tracking; flush beats stall beats load
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state       <= RUN;
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_val  <= '0;
            ex_rs2_val  <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_opcode   <= '0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
            ex_is_load  <= 1'b0;
            ex_reg_wen  <= 1'b0;
        end else begin
            case (state)
                RUN:     state <= stall_out ? BUBBLE : RUN;
                BUBBLE:  state <= RUN;
                default: state <= RUN;
            endcase
            if (ex_flush || stall_out) begin
                ex_valid   <= 1'b0;
                ex_is_load <= 1'b0;
                ex_reg_wen <= 1'b0;
            end else begin
                ex_valid    <= if_id_valid;
                ex_pc       <= if_id_pc;
                ex_rs1_val  <= rs1_val;
                ex_rs2_val  <= rs2_val;
                ex_imm      <= imm;
                ex_rs1      <= rs1;
                ex_rs2      <= rs2;
                ex_rd       <= rd;
                ex_opcode   <= opcode;
                ex_funct3   <= if_id_instr[14:12];
                ex_funct7b5 <= if_id_instr[30];
                ex_is_load  <= is_load_d && if_id_valid;
                ex_reg_wen  <= reg_wen_d && if_id_valid;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed cases with literal expectations plus
// randomized traffic, all checked against a behavioural ID/EX model.
module tb_id_ex_stage;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        if_id_valid;
    logic [31:0] if_id_pc, if_id_instr;
    logic [4:0]  rf_read1, rf_read2;
    logic [31:0] rf_data1, rf_data2;
    logic        wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_flush;
    logic        stall_out, ex_valid;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5, ex_is_load, ex_reg_wen;

    id_ex_stage dut (
        .Clk(Clk), .Rst(Rst), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
        .if_id_instr(if_id_instr), .rf_read1(rf_read1), .rf_read2(rf_read2),
        .rf_data1(rf_data1), .rf_data2(rf_data2), .wb_wen(wb_wen), .wb_rd(wb_rd),
        .wb_data(wb_data), .ex_flush(ex_flush), .stall_out(stall_out),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val),
        .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
        .ex_funct7b5(ex_funct7b5), .ex_is_load(ex_is_load), .ex_reg_wen(ex_reg_wen)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs1v, rs2v, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7b5, is_load, reg_wen;
    } ex_t;

    ex_t m;
    bit  m_known = 1'b0;
    bit  m_cmp_all = 1'b0;
    bit  last_stall = 1'b0;
    int  errors = 0;
    int  checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference decode written from the ISA field definitions
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        logic [31:0] s31, u;
        s31 = (i[31]) ? 32'hFFFF_FFFF : 32'h0;
        u   = i;
        case (i[6:0])
            7'h03, 7'h13, 7'h67: return 32'($signed(u) >>> 20);
            7'h23: return (32'($signed(u) >>> 25) << 5) | 32'(i[11:7]);
            7'h63: return (s31 << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
            7'h37, 7'h17: return u & 32'hFFFF_F000;
            7'h6F: return (s31 << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit uses_rs1(input logic [6:0] op);
        return !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
    endfunction

    function automatic bit uses_rs2(input logic [6:0] op);
        return (op == 7'h33 || op == 7'h23 || op == 7'h63);
    endfunction

    function automatic bit writes_rd(input logic [6:0] op);
        return (op == 7'h37 || op == 7'h17 || op == 7'h6F || op == 7'h67 ||
                op == 7'h03 || op == 7'h13 || op == 7'h33);
    endfunction

    function automatic logic [31:0] ref_operand(input logic [4:0] r, input logic [31:0] rf);
        if (r == 5'd0) return 32'h0;
        if (wb_wen && wb_rd == r) return wb_data;
        return rf;
    endfunction

    function automatic bit ref_stall();
        logic [4:0] r1, r2;
        logic [6:0] op;
        bit hz;
        r1 = if_id_instr[19:15];
        r2 = if_id_instr[24:20];
        op = if_id_instr[6:0];
        hz = if_id_valid && m.valid && m.is_load && m.rd != 5'd0 &&
             ((uses_rs1(op) && m.rd == r1) || (uses_rs2(op) && m.rd == r2));
        return hz && !ex_flush;
    endfunction

    function automatic ex_t ref_decode();
        ex_t e;
        e.valid   = if_id_valid;
        e.pc      = if_id_pc;
        e.rs1     = if_id_instr[19:15];
        e.rs2     = if_id_instr[24:20];
        e.rd      = if_id_instr[11:7];
        e.op      = if_id_instr[6:0];
        e.f3      = if_id_instr[14:12];
        e.f7b5    = if_id_instr[30];
        e.imm     = ref_imm(if_id_instr);
        e.rs1v    = ref_operand(e.rs1, rf_data1);
        e.rs2v    = ref_operand(e.rs2, rf_data2);
        e.is_load = if_id_valid && e.op == 7'h03;
        e.reg_wen = if_id_valid && writes_rd(e.op) && e.rd != 5'd0;
        return e;
    endfunction

    // Model of the ID/EX register, advanced on each rising edge
    always @(posedge Clk) begin
        if (!Rst) begin
            m         = '0;
            m_known   = 1'b1;
            m_cmp_all = 1'b1;
        end else if (m_known) begin
            if (ex_flush || ref_stall()) begin
                m.valid   = 1'b0;
                m.is_load = 1'b0;
                m.reg_wen = 1'b0;
                m_cmp_all = 1'b0;
            end else begin
                m         = ref_decode();
                m_cmp_all = 1'b1;
            end
        end
    end

    // Compare process: every cycle, mid-period
    always @(negedge Clk) begin
        if (m_known) begin
            last_stall = ref_stall();
            chk("stall_out", 32'(stall_out), 32'(last_stall));
            chk("rf_read1", 32'(rf_read1), 32'(if_id_instr[19:15]));
            chk("rf_read2", 32'(rf_read2), 32'(if_id_instr[24:20]));
            chk("ex_valid", 32'(ex_valid), 32'(m.valid));
            chk("ex_is_load", 32'(ex_is_load), 32'(m.is_load));
            chk("ex_reg_wen", 32'(ex_reg_wen), 32'(m.reg_wen));
            if (m_cmp_all) begin
                chk("ex_pc", ex_pc, m.pc);
                chk("ex_rs1_val", ex_rs1_val, m.rs1v);
                chk("ex_rs2_val", ex_rs2_val, m.rs2v);
                chk("ex_imm", ex_imm, m.imm);
                chk("ex_rs1", 32'(ex_rs1), 32'(m.rs1));
                chk("ex_rs2", 32'(ex_rs2), 32'(m.rs2));
                chk("ex_rd", 32'(ex_rd), 32'(m.rd));
                chk("ex_opcode", 32'(ex_opcode), 32'(m.op));
                chk("ex_funct3", 32'(ex_funct3), 32'(m.f3));
                chk("ex_funct7b5", 32'(ex_funct7b5), 32'(m.f7b5));
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] i;
        i = $urandom;
        case ($urandom_range(0, 11))
            0, 1, 2: i[6:0] = 7'h03;
            3:       i[6:0] = 7'h13;
            4:       i[6:0] = 7'h17;
            5:       i[6:0] = 7'h23;
            6, 7:    i[6:0] = 7'h33;
            8:       i[6:0] = 7'h37;
            9:       i[6:0] = 7'h63;
            10:      i[6:0] = 7'h67;
            default: i[6:0] = ($urandom_range(0, 1) == 0) ? 7'h6F : 7'($urandom);
        endcase
        i[11:7]  = 5'($urandom_range(0, 3));
        i[19:15] = 5'($urandom_range(0, 3));
        i[24:20] = 5'($urandom_range(0, 3));
        return i;
    endfunction

    localparam logic [31:0] I_ADDI  = 32'hFFF00093;  // addi x1,x0,-1
    localparam logic [31:0] I_LUI2  = 32'h12345137;  // lui  x2,0x12345
    localparam logic [31:0] I_BEQ   = 32'hFE000EE3;  // beq  x0,x0,-4
    localparam logic [31:0] I_ADD3  = 32'h000281B3;  // add  x3,x5,x0
    localparam logic [31:0] I_LW6   = 32'h0000A303;  // lw   x6,0(x1)
    localparam logic [31:0] I_ADD7  = 32'h002303B3;  // add  x7,x6,x2
    localparam logic [31:0] I_LUI8  = 32'h00030437;  // lui  x8,0x30 (rs1 field = 6)
    localparam logic [31:0] I_LW0   = 32'h0000A003;  // lw   x0,0(x1)
    localparam logic [31:0] I_ADD1  = 32'h000000B3;  // add  x1,x0,x0
    localparam logic [31:0] I_SW6   = 32'h0060A023;  // sw   x6,0(x1)

    initial begin
        Rst = 1'b0; if_id_valid = 1'b1; if_id_pc = 32'h100; if_id_instr = I_ADDI;
        rf_data1 = 32'h0; rf_data2 = 32'h0; wb_wen = 1'b0; wb_rd = 5'd0;
        wb_data = 32'h0; ex_flush = 1'b0;

        // Reset held two cycles with a valid instruction in decode
        repeat (2) tick();
        chk("rst_ex_valid", 32'(ex_valid), 32'h0);
        chk("rst_ex_imm", ex_imm, 32'h0);
        chk("rst_ex_rd", 32'(ex_rd), 32'h0);
        chk("rst_stall", 32'(stall_out), 32'h0);

        Rst = 1'b1;
        tick();
        chk("addi_valid", 32'(ex_valid), 32'h1);
        chk("addi_imm", ex_imm, 32'hFFFF_FFFF);
        chk("addi_rd", 32'(ex_rd), 32'h1);
        chk("addi_wen", 32'(ex_reg_wen), 32'h1);
        chk("addi_pc", ex_pc, 32'h100);

        if_id_instr = I_LUI2; if_id_pc = 32'h104;
        tick();
        chk("lui_imm", ex_imm, 32'h1234_5000);

        if_id_instr = I_BEQ; if_id_pc = 32'h108;
        tick();
        chk("beq_imm", ex_imm, 32'hFFFF_FFFC);
        chk("beq_wen", 32'(ex_reg_wen), 32'h0);

        // Write-back bypass, then x0 write never bypassed
        if_id_instr = I_ADD3; rf_data1 = 32'h11; rf_data2 = 32'h22;
        wb_wen = 1'b1; wb_rd = 5'd5; wb_data = 32'hAA;
        tick();
        chk("byp_rs1", ex_rs1_val, 32'hAA);
        chk("byp_rs2", ex_rs2_val, 32'h0);
        wb_rd = 5'd0;
        tick();
        chk("nobyp_rs1", ex_rs1_val, 32'h11);
        wb_wen = 1'b0;

        // Load-use: one stall cycle, then the add arrives
        if_id_instr = I_LW6;
        tick();
        if_id_instr = I_ADD7; #1;
        chk("lu_stall", 32'(stall_out), 32'h1);
        tick();
        chk("lu_bubble", 32'(ex_valid), 32'h0);
        chk("lu_stall_drop", 32'(stall_out), 32'h0);
        tick();
        chk("lu_add_valid", 32'(ex_valid), 32'h1);
        chk("lu_add_rs1", 32'(ex_rs1), 32'h6);
        chk("lu_add_rd", 32'(ex_rd), 32'h7);

        // LUI does not read rs1
        if_id_instr = I_LW6;
        tick();
        if_id_instr = I_LUI8; #1;
        chk("lui_nostall", 32'(stall_out), 32'h0);
        tick();
        chk("lui8_rd", 32'(ex_rd), 32'h8);

        // Flush beats the hazard
        if_id_instr = I_LW6;
        tick();
        if_id_instr = I_ADD7; ex_flush = 1'b1; #1;
        chk("fl_stall", 32'(stall_out), 32'h0);
        tick();
        chk("fl_valid", 32'(ex_valid), 32'h0);
        ex_flush = 1'b0; #1;
        chk("fl_next_stall", 32'(stall_out), 32'h0);
        tick();
        chk("fl_next_valid", 32'(ex_valid), 32'h1);

        // Load to x0 never stalls
        if_id_instr = I_LW0;
        tick();
        if_id_instr = I_ADD1; #1;
        chk("x0_nostall", 32'(stall_out), 32'h0);
        tick();

        // Store reads rs2
        if_id_instr = I_LW6;
        tick();
        if_id_instr = I_SW6; #1;
        chk("sw_stall", 32'(stall_out), 32'h1);
        tick();
        tick();
        chk("sw_opcode", 32'(ex_opcode), 32'h23);

        // Reset in the middle of a stall
        if_id_instr = I_LW6;
        tick();
        if_id_instr = I_ADD7; #1;
        chk("rs_stall", 32'(stall_out), 32'h1);
        Rst = 1'b0;
        tick();
        chk("rs_valid", 32'(ex_valid), 32'h0);
        Rst = 1'b1;
        tick();
        chk("rs_after_valid", 32'(ex_valid), 32'h1);

        // Randomized traffic; IF/ID holds while the model says stall
        for (int n = 0; n < 3000; n++) begin
            if (!last_stall) begin
                if_id_valid = ($urandom_range(0, 7) != 0);
                if_id_instr = rnd_instr();
                if_id_pc    = $urandom;
            end
            rf_data1 = $urandom;
            rf_data2 = $urandom;
            wb_wen   = 1'($urandom_range(0, 1));
            wb_rd    = 5'($urandom_range(0, 3));
            wb_data  = $urandom;
            ex_flush = ($urandom_range(0, 15) == 0);
            Rst      = ($urandom_range(0, 63) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
